// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared state encoding, requester ids and array geometry defaults for the L2 array arbiter
`ifndef L2ARB_SET_COUNT
`define L2ARB_SET_COUNT 4
`endif
`ifndef L2ARB_ASSOC
`define L2ARB_ASSOC 2
`endif
package l2_arb_pkg;
  typedef enum logic {INIT, RUN} state_e;
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
  localparam int L2_SET_COUNT = `L2ARB_SET_COUNT;
  localparam int L2_ASSOC = `L2ARB_ASSOC;
  localparam int L2_SET_W = $clog2(L2_SET_COUNT);
  localparam int L2_WAY_W = $clog2(L2_ASSOC);
endpackage

// File: rtl/l2_rr_arbiter.sv
// l2_rr_arbiter: two-input round-robin grant with a pointer to the side favoured on contention
module l2_rr_arbiter
  import l2_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  // lone requester wins outright; on contention the pointer decides; any grant favours the other side next
  always_comb begin
    gnt[REQ_I] = en & req[REQ_I] & (~req[REQ_D] | ptr_q == REQ_I);
    gnt[REQ_D] = en & req[REQ_D] & (~req[REQ_I] | ptr_q == REQ_D);
    ptr_d = gnt[REQ_I] ? REQ_D : gnt[REQ_D] ? REQ_I : ptr_q;
  end
  // pointer register, favouring the instruction side out of reset
  always_ff @(posedge clk) ptr_q <= rst ? REQ_I : ptr_d;
endmodule

// File: rtl/l2_array_arbiter.sv
// l2_array_arbiter: round-robin sharing of the single-port L2 array; optional clear sweep under L2ARB_INIT_CLEAR_EN
module l2_array_arbiter
  import l2_arb_pkg::*;
#(
  parameter int SET_COUNT = L2_SET_COUNT,
  parameter int ASSOC = L2_ASSOC,
  parameter int DATA_W = 32,
  parameter int SET_W = $clog2(SET_COUNT),
  parameter int WAY_W = $clog2(ASSOC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [SET_W-1:0]  i_set,
  input  logic [WAY_W-1:0]  i_way,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [SET_W-1:0]  d_set,
  input  logic [WAY_W-1:0]  d_way,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [SET_W-1:0]  mem_set,
  output logic [WAY_W-1:0]  mem_way,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_busy
);
  state_e state_q, state_d;
  logic sweep;
  logic [SET_W-1:0] sw_set;
  logic [WAY_W-1:0] sw_way;
  logic [1:0] gnt;
  logic mem_we_q, i_rvalid_q, d_rvalid_q;
  logic [SET_W-1:0] mem_set_q;
  logic [WAY_W-1:0] mem_way_q;
  logic [DATA_W-1:0] mem_wdata_q;
`ifdef L2ARB_INIT_CLEAR_EN
  logic [SET_W-1:0] set_q, set_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic last;
  // clear sweep: way is the inner loop, set the outer; parks on the final entry and hands over to RUN
  always_comb begin
    last = set_q == SET_W'(SET_COUNT - 1) && way_q == WAY_W'(ASSOC - 1);
    sweep = ~rst & state_q == INIT;
    state_d = sweep && last ? RUN : state_q;
    way_d = !sweep || last ? way_q : way_q == WAY_W'(ASSOC - 1) ? '0 : way_q + 1'b1;
    set_d = !sweep || last || way_q != WAY_W'(ASSOC - 1) ? set_q : set_q + 1'b1;
    sw_set = set_q;
    sw_way = way_q;
  end
  // state and sweep counter; reset restarts the sweep from entry 0
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= INIT;
      set_q <= '0;
      way_q <= '0;
    end else begin
      state_q <= state_d;
      set_q <= set_d;
      way_q <= way_d;
    end
  assign init_busy = state_q == INIT;
`else
  // no clear sweep: the array is usable straight out of reset
  always_comb begin
    sweep = 1'b0;
    state_d = RUN;
    sw_set = '0;
    sw_way = '0;
  end
  // state register pinned to RUN
  always_ff @(posedge clk) state_q <= rst ? RUN : state_d;
  assign init_busy = 1'b0;
`endif
  l2_rr_arbiter u_rr (
    .clk(clk),
    .rst(rst),
    .en (~rst & state_q == RUN),
    .req({d_req, i_req}),
    .gnt(gnt)
  );
  assign i_gnt = gnt[REQ_I];
  assign d_gnt = gnt[REQ_D];
  // array port mux: sweep writes zeros, otherwise the granted side, otherwise hold the last access
  always_comb begin
    mem_en = sweep | gnt[REQ_I] | gnt[REQ_D];
    mem_we = sweep ? 1'b1 : gnt[REQ_D] ? d_we : gnt[REQ_I] ? i_we : mem_we_q;
    mem_set = sweep ? sw_set : gnt[REQ_D] ? d_set : gnt[REQ_I] ? i_set : mem_set_q;
    mem_way = sweep ? sw_way : gnt[REQ_D] ? d_way : gnt[REQ_I] ? i_way : mem_way_q;
    mem_wdata = sweep ? '0 : gnt[REQ_D] ? d_wdata : gnt[REQ_I] ? i_wdata : mem_wdata_q;
  end
  // last-access hold registers and the one-cycle read strobes
  always_ff @(posedge clk)
    if (rst) begin
      mem_we_q <= 1'b0;
      mem_set_q <= '0;
      mem_way_q <= '0;
      mem_wdata_q <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      mem_we_q <= mem_we;
      mem_set_q <= mem_set;
      mem_way_q <= mem_way;
      mem_wdata_q <= mem_wdata;
      i_rvalid_q <= gnt[REQ_I] & ~i_we;
      d_rvalid_q <= gnt[REQ_D] & ~d_we;
    end
  assign i_rvalid = i_rvalid_q & ~rst;
  assign d_rvalid = d_rvalid_q & ~rst;
  assign i_rdata = i_rvalid ? mem_rdata : '0;
  assign d_rdata = d_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_l2_array_arbiter.sv
// tb_l2_array_arbiter: randomized and directed checks of the L2 array arbiter against a behavioural model
module tb_l2_array_arbiter;
  localparam int SC = 4;
  localparam int AS = 2;
  localparam int N = SC * AS;
`ifdef L2ARB_INIT_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 1'b0, i_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [1:0] i_set = '0, d_set = '0;
  logic [0:0] i_way = '0, d_way = '0;
  logic [31:0] i_wdata = '0, d_wdata = '0;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, init_busy;
  logic [31:0] i_rdata, d_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [1:0] mem_set;
  logic [0:0] mem_way;
  always #5 clk = ~clk;
  l2_array_arbiter #(.SET_COUNT(SC), .ASSOC(AS), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_set(i_set), .i_way(i_way), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_set(d_set), .d_way(d_way), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_set(mem_set), .mem_way(mem_way),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .init_busy(init_busy)
  );
  // array stand-in: one-cycle read latency, preloaded with random contents
  logic [31:0] arr [N];
  logic [31:0] seed [N];
  bit preload = 1'b1;
  always @(posedge clk)
    if (preload) arr <= seed;
    else if (mem_en) begin
      if (mem_we) arr[int'(mem_set) * AS + int'(mem_way)] <= mem_wdata;
      else mem_rdata <= arr[int'(mem_set) * AS + int'(mem_way)];
    end
  int chk_cnt = 0, pass_cnt = 0;
  logic [31:0] ref_mem [N];
  int sweep_idx, favor;
  bit ev_i, ev_d, win_i, win_d;
  logic [31:0] ed_i, ed_d;
  int h_we, h_set, h_way;
  logic [31:0] h_wd;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_reset();
    sweep_idx = CLR ? 0 : N;
    favor = 0;
    ev_i = 0; ev_d = 0;
    h_we = 0; h_set = 0; h_way = 0; h_wd = '0;
  endtask
  task automatic apply_rst();
    @(negedge clk);
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    #1;
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_gnt", {i_gnt, d_gnt}, 0);
    check("rst_mem_en", mem_en, 0);
    @(negedge clk);
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_set", mem_set, 0);
    check("rst_mem_way", mem_way, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_init_busy", init_busy, CLR);
    check("rst_d_rdata", d_rdata, 0);
    model_reset();
  endtask
  task automatic step(input bit ir, input bit iw, input int is, input int iwy, input logic [31:0] iwd,
                      input bit dr, input bit dw, input int ds, input int dwy, input logic [31:0] dwd);
    int w, idx;
    @(negedge clk);
    rst = 1'b0;
    i_req = ir; i_we = iw; i_set = 2'(is); i_way = 1'(iwy); i_wdata = iwd;
    d_req = dr; d_we = dw; d_set = 2'(ds); d_way = 1'(dwy); d_wdata = dwd;
    #1;
    check("i_rvalid", i_rvalid, ev_i);
    check("d_rvalid", d_rvalid, ev_d);
    if (ev_i) check("i_rdata", i_rdata, ed_i);
    if (ev_d) check("d_rdata", d_rdata, ed_d);
    ev_i = 0; ev_d = 0;
    if (sweep_idx < N) begin
      check("sweep_busy", init_busy, 1);
      check("sweep_en", mem_en, 1);
      check("sweep_gnt", {i_gnt, d_gnt}, 0);
      h_we = 1; h_set = sweep_idx / AS; h_way = sweep_idx % AS; h_wd = '0;
      ref_mem[sweep_idx] = '0;
      sweep_idx++;
      win_i = 0; win_d = 0;
    end else begin
      check("run_busy", init_busy, 0);
      w = ir && dr ? favor : ir ? 0 : dr ? 1 : -1;
      win_i = w == 0; win_d = w == 1;
      check("i_gnt", i_gnt, win_i);
      check("d_gnt", d_gnt, win_d);
      check("mem_en", mem_en, w >= 0);
      if (w >= 0) begin
        h_we = w ? dw : iw; h_set = w ? ds : is; h_way = w ? dwy : iwy; h_wd = w ? dwd : iwd;
        favor = 1 - w;
        idx = h_set * AS + h_way;
        if (h_we) ref_mem[idx] = h_wd;
        else if (w == 0) begin ev_i = 1; ed_i = ref_mem[idx]; end
        else begin ev_d = 1; ed_d = ref_mem[idx]; end
      end
    end
    check("mem_we", mem_we, h_we);
    check("mem_set", mem_set, h_set);
    check("mem_way", mem_way, h_way);
    check("mem_wdata", mem_wdata, h_wd);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic finish_sweep();
    int n = 0;
    while (sweep_idx < N && n < 2 * N) begin idle(); n++; end
  endtask
  bit pir, piw, pdr, pdw;
  int pis, piy, pds, pdy, tries;
  logic [31:0] piwd, pdwd;
  initial begin
    for (int i = 0; i < N; i++) begin seed[i] = $urandom; ref_mem[i] = seed[i]; end
    apply_rst();
    preload = 1'b0;
    // interrupted sweep, then a complete one
    for (int k = 0; k < 4; k++) idle();
    apply_rst();
    finish_sweep();
    idle();
    // single read of 2/1
    step(0, 0, 0, 0, 0, 1, 0, 2, 1, 0);
    idle();
    // contention: both sides hold reads for 4 cycles
    for (int k = 0; k < 4; k++) step(1, 0, k % SC, 0, 0, 1, 0, (k + 1) % SC, 1, 0);
    idle();
    // write then read of 3/0
    step(1, 1, 3, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 3, 0, 0);
    idle();
    check("wr_rd_value", d_rdata, 32'hDEADBEEF);
    // back-to-back writes to the same entry from both sides, later one sticks
    step(1, 1, 1, 1, 32'h1111_AAAA, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h2222_BBBB);
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle();
    // reset while a read response is pending
    step(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    apply_rst();
    // request held across reset/sweep until granted
    tries = 0;
    win_i = 0;
    while (!win_i && tries < 3 * N) begin step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tries++; end
    check("held_req_granted", win_i, 1);
    check("held_req_latency", tries, CLR ? N + 1 : 1);
    idle();
    // randomized traffic with hold-until-grant requesters
    pir = 0; pdr = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pir) begin
        pir = $urandom_range(0, 9) < 6; piw = 1'($urandom_range(0, 1));
        pis = $urandom_range(0, SC - 1); piy = $urandom_range(0, AS - 1); piwd = $urandom;
      end
      if (!pdr) begin
        pdr = $urandom_range(0, 9) < 6; pdw = 1'($urandom_range(0, 1));
        pds = $urandom_range(0, SC - 1); pdy = $urandom_range(0, AS - 1); pdwd = $urandom;
      end
      step(pir, piw, pis, piy, piwd, pdr, pdw, pds, pdy, pdwd);
      if (win_i) pir = 0;
      if (win_d) pdr = 0;
    end
    idle();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
